jbus_sequencer: RTL and testbench
=================================

Name: jbus_sequencer

Overview:
- Bus-transfer initiator for the register file: drives the per-register enable (`we`) and set (`ws`) lines that `jrreg` registers respond to.
- Moves one byte per request from a source register, or from the host, onto the shared 8-bit bus and latches it into a destination register, or returns it to the host.
- Step order follows the CPU stepper discipline: enable source, let the bus settle, pulse set, hold, release.
- Sits between the control unit (or a test host) and the register array.

Parameters:
- NREGS, 4, number of attached registers. Indices 0..NREGS-1 are registers; index NREGS is the host.
- SETTLE, 1, cycles the source enable is held before the set pulse (≥1).
- SW, $clog2(NREGS+1), width of the source/destination select fields.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_src  input  SW  source index.
- req_dst  input  SW  destination index.
- req_data  input  8  byte driven on the bus when req_src==NREGS.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  qualifies rsp_valid: request was rejected.
- rsp_data  output  8  byte captured when req_dst==NREGS.
- bus_in  input  8  sampled value of the shared bus.
- bus_out  output  8  host byte for the bus.
- bus_oe  output  1  host drives the bus.
- reg_we  output  NREGS  one-hot register enables.
- reg_ws  output  NREGS  one-hot register sets.
- busy  output  1  transfer in progress (state != IDLE).

Behaviour:
- Reset: at a reset edge all outputs go 0, rsp_data goes 0 and the state goes to IDLE. This applies mid-transfer too: strobes drop at that edge, no rsp_valid is issued, and the aborted request is lost.
- States: IDLE, EN, SET, HOLD, DONE.
- Handshake: req_ready=1 only in IDLE and DONE. A request is accepted on an edge where req_valid && req_ready. req_src, req_dst and req_data are latched at acceptance; later input changes are ignored.
- Validity check at accept: reject if src>NREGS, dst>NREGS, or src==dst (this includes host-to-host).
  - Rejected request: next state DONE with rsp_err=1; no we, ws or oe asserted.
- Valid request: next state EN.
  - EN lasts SETTLE cycles: reg_we[src]=1, or bus_oe=1 with bus_out=req_data if src==NREGS.
  - SET lasts 1 cycle: source enable stays asserted; reg_ws[dst]=1 if dst<NREGS. If dst==NREGS, rsp_data<=bus_in at the edge ending SET.
  - HOLD lasts 1 cycle: ws=0, source enable still asserted.
  - DONE lasts 1 cycle: all strobes 0, rsp_valid=1, rsp_err=0.
- Latency: for acceptance at edge T, source enable is high from T+1 through T+SETTLE+2 and ws is high only in cycle T+SETTLE+1. rsp_valid is in cycle T+SETTLE+3; with SETTLE=1 that is T+4. Rejected requests give rsp_valid at T+1.
- Back-to-back: a request accepted in DONE enters EN (or DONE if rejected) on the next edge. This gives at least one cycle with all strobes low between transfers.
- Invariants:
  - reg_we and reg_ws are each at most one-hot.
  - ws is never asserted outside SET.
  - bus_oe and any reg_we are never high together.
  - ws and the source enable never change on the same edge.
- rsp_data holds its previous value unless a host-destination transfer completes.
- bus_out is 0 whenever bus_oe=0.

Decomposition:
- Package jbus_pkg holds:
  - state enum (IDLE, EN, SET, HOLD, DONE);
  - function host_idx(NREGS);
  - function sel_width(NREGS).
- One sub-module, jstrobe_decode(index, en) -> NREGS one-hot. It outputs 0 when en=0 or when index≥NREGS. The sequencer instantiates it twice: once for reg_we and once for reg_ws.

Test Plan:
- Reg-to-reg: preload the bench model r1=8'hA5; request src=1, dst=2 → reg_we=4'b0010 for cycles T+1..T+3, reg_ws=4'b0100 only at T+2, rsp_valid at T+4 with rsp_err=0, r2=8'hA5.
- Host write: src=4 (NREGS=4), dst=0, req_data=8'h3C → bus_oe=1 and bus_out=8'h3C for T+1..T+3, reg_ws=4'b0001 at T+2, reg_we stays 0, register 0 reads 8'h3C afterwards.
- Host read: r3=8'h7E; src=3, dst=4 → reg_ws stays 0, rsp_data=8'h7E with rsp_valid at T+4; a following host-write request leaves rsp_data at 8'h7E.
- Errors:
  - src=dst=2 → rsp_valid=1 and rsp_err=1 at T+1, no strobes;
  - src=5 (NREGS=4) → same response;
  - src=dst=4 (host-to-host) → same response.
- Back-to-back plus SETTLE=3 variant:
  - hold req_valid high with two valid requests → second accepted in DONE, at least one all-strobes-low cycle between transfers;
  - with SETTLE=3, ws rises at T+4 and rsp_valid at T+6.
- Reset in SET: assert reset during SET → reg_we, reg_ws and busy are 0 after that edge, no rsp_valid, req_ready=1 once reset deasserts.

Source files
------------

// File: rtl/jbus_pkg.sv
// rtl/jbus_pkg.sv - shared types and helpers for the register-bus sequencer
package jbus_pkg;

    // Byte width of the shared register bus
    localparam int BYTE_W = 8;

    // Transfer phases: source enable, set pulse, hold, then a one-cycle response
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN   = 3'd1,
        SET  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } jbus_state_e;

    // The host sits one index past the last register
    function automatic int host_idx(input int nregs);
        return nregs;
    endfunction

    // Select fields must reach the host index as well as every register
    function automatic int sel_width(input int nregs);
        return (nregs < 1) ? 1 : $clog2(nregs + 1);
    endfunction

endpackage

// File: rtl/jstrobe_decode.sv
// rtl/jstrobe_decode.sv - index to one-hot register strobe decoder
module jstrobe_decode #(
    parameter int NREGS = 4,
    parameter int IW    = 3
) (
    input  logic [IW-1:0]    index,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // Indices at or beyond NREGS (the host slot) never match a register line
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en && (index == IW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jbus_sequencer.sv
// rtl/jbus_sequencer.sv - one-byte register bus transfer sequencer
module jbus_sequencer
    import jbus_pkg::*;
#(
    parameter int NREGS  = 4,
    parameter int SETTLE = 1,
    parameter int SW     = sel_width(NREGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SW-1:0]      req_src,
    input  logic [SW-1:0]      req_dst,
    input  logic [BYTE_W-1:0]  req_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [BYTE_W-1:0]  rsp_data,
    input  logic [BYTE_W-1:0]  bus_in,
    output logic [BYTE_W-1:0]  bus_out,
    output logic               bus_oe,
    output logic [NREGS-1:0]   reg_we,
    output logic [NREGS-1:0]   reg_ws,
    output logic               busy
);

    localparam logic [SW-1:0] HOST = SW'(host_idx(NREGS));
    localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);

    jbus_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     src_q, src_d;
    logic [SW-1:0]     dst_q, dst_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [BYTE_W-1:0] rsp_data_q, rsp_data_d;

    logic accept;
    logic req_bad;
    logic src_en;
    logic src_host;
    logic we_en;
    logic ws_en;

    // New requests are taken only when no transfer owns the bus
    assign req_ready = (state_q == IDLE) || (state_q == DONE);
    assign accept    = req_valid && req_ready;
    assign req_bad   = (req_src > HOST) || (req_dst > HOST) || (req_src == req_dst);

    // Next-state, request latching and host-read capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        data_d     = data_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    src_d   = req_src;
                    dst_d   = req_dst;
                    data_d  = req_data;
                    err_d   = req_bad;
                    cnt_d   = LOAD;
                    state_d = req_bad ? DONE : EN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            EN: begin
                // Source stays enabled SETTLE cycles so the bus is stable before the set pulse
                if (cnt_q == '0) begin
                    state_d = SET;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SET: begin
                state_d = HOLD;
                if (dst_q == HOST) begin
                    rsp_data_d = bus_in;
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Source enable spans EN through HOLD so set never edges together with enable
    always_comb begin
        src_en    = (state_q == EN) || (state_q == SET) || (state_q == HOLD);
        src_host  = (src_q == HOST);
        we_en     = src_en && !src_host;
        ws_en     = (state_q == SET);
        bus_oe    = src_en && src_host;
        bus_out   = bus_oe ? data_q : '0;
        rsp_valid = (state_q == DONE);
        rsp_err   = (state_q == DONE) && err_q;
        busy      = (state_q != IDLE);
        rsp_data  = rsp_data_q;
    end

    jstrobe_decode #(
        .NREGS (NREGS),
        .IW    (SW)
    ) u_we_decode (
        .index  (src_q),
        .en     (we_en),
        .onehot (reg_we)
    );

    // A host destination decodes to no register, so no set line fires
    jstrobe_decode #(
        .NREGS (NREGS),
        .IW    (SW)
    ) u_ws_decode (
        .index  (dst_q),
        .en     (ws_en),
        .onehot (reg_ws)
    );

    // Bus-protocol invariants the register array depends on
    a_we_onehot:  assert property (@(posedge clk) $onehot0(reg_we));
    a_ws_onehot:  assert property (@(posedge clk) $onehot0(reg_ws));
    a_no_contend: assert property (@(posedge clk) !(bus_oe && (|reg_we)));
    a_ws_in_set:  assert property (@(posedge clk) (|reg_ws) |-> (state_q == SET));
    a_bus_quiet:  assert property (@(posedge clk) !bus_oe |-> (bus_out == '0));

endmodule

// File: tb/tb_jbus_sequencer.sv
// tb/tb_jbus_sequencer.sv - randomized self-checking bench for jbus_sequencer
module tb_jbus_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset     [2];
    logic       req_valid [2];
    logic       req_ready [2];
    logic [2:0] req_src   [2];
    logic [2:0] req_dst   [2];
    logic [7:0] req_data  [2];
    logic       rsp_valid [2];
    logic       rsp_err   [2];
    logic [7:0] rsp_data  [2];
    logic [7:0] bus_in    [2];
    logic [7:0] bus_out   [2];
    logic       bus_oe    [2];
    logic [3:0] reg_we    [2];
    logic [3:0] reg_ws    [2];
    logic       busy      [2];

    logic [7:0] env_regs [2][N];
    logic [7:0] exp_regs [2][N];
    logic [7:0] exp_rsp  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jbus_sequencer #(.NREGS(N), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_src(req_src[0]), .req_dst(req_dst[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_data(rsp_data[0]),
        .bus_in(bus_in[0]), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]),
        .reg_we(reg_we[0]), .reg_ws(reg_ws[0]), .busy(busy[0])
    );

    jbus_sequencer #(.NREGS(N), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_src(req_src[1]), .req_dst(req_dst[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_data(rsp_data[1]),
        .bus_in(bus_in[1]), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]),
        .reg_we(reg_we[1]), .reg_ws(reg_ws[1]), .busy(busy[1])
    );

    // Register array environment: enabled register or host drives the bus, set latches it
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus_in[k] = 8'h00;
            if (bus_oe[k]) begin
                bus_in[k] = bus_out[k];
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (reg_we[k][i]) bus_in[k] = env_regs[k][i];
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (reset[k]) env_regs[k][i] <= 8'h00;
                else if (reg_ws[k][i]) env_regs[k][i] <= bus_in[k];
            end
        end
    end

    // One transfer on instance k, checked cycle by cycle against timing derived from SETTLE
    task automatic do_xfer(input int k, input logic [2:0] src, input logic [2:0] dst,
                           input logic [7:0] data, input bit hold,
                           input logic [2:0] nsrc, input logic [2:0] ndst,
                           input logic [7:0] ndata, input int rst_at, output int waited);
        int s, last;
        bit ok;
        logic [3:0] e_we, e_ws;
        logic e_en, e_oe, e_rv, e_er;
        logic [7:0] e_bo, e_rd, rsp_new, reg_new;
        s    = (k == 0) ? 1 : 3;
        ok   = (src <= 3'(N)) && (dst <= 3'(N)) && (src != dst);
        last = ok ? s + 3 : 1;
        rsp_new = exp_rsp[k];
        reg_new = 8'h00;
        if (ok && dst == 3'(N)) rsp_new = exp_regs[k][src];
        if (ok && dst < 3'(N)) reg_new = (src == 3'(N)) ? data : exp_regs[k][src];
        req_src[k] = src; req_dst[k] = dst; req_data[k] = data; req_valid[k] = 1'b1;
        waited = 0;
        while (req_ready[k] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (waited >= 20) begin
            fails++;
            $display("FAIL accept_timeout k=%0d ready=%b required=1", k, req_ready[k]);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            e_en = ok && (n <= s + 2);
            e_we = (e_en && src < 3'(N)) ? (4'b0001 << src) : 4'b0000;
            e_oe = e_en && (src == 3'(N));
            e_bo = e_oe ? data : 8'h00;
            e_ws = (ok && n == s + 1 && dst < 3'(N)) ? (4'b0001 << dst) : 4'b0000;
            e_rv = (n == last);
            e_er = e_rv && !ok;
            e_rd = (ok && n >= s + 2) ? rsp_new : exp_rsp[k];
            tests += 9;
            if (reg_we[k] !== e_we) begin fails++; $display("FAIL reg_we k=%0d n=%0d got=%b exp=%b", k, n, reg_we[k], e_we); end
            if (reg_ws[k] !== e_ws) begin fails++; $display("FAIL reg_ws k=%0d n=%0d got=%b exp=%b", k, n, reg_ws[k], e_ws); end
            if (bus_oe[k] !== e_oe) begin fails++; $display("FAIL bus_oe k=%0d n=%0d got=%b exp=%b", k, n, bus_oe[k], e_oe); end
            if (bus_out[k] !== e_bo) begin fails++; $display("FAIL bus_out k=%0d n=%0d got=%h exp=%h", k, n, bus_out[k], e_bo); end
            if (rsp_valid[k] !== e_rv) begin fails++; $display("FAIL rsp_valid k=%0d n=%0d got=%b exp=%b", k, n, rsp_valid[k], e_rv); end
            if (rsp_err[k] !== e_er) begin fails++; $display("FAIL rsp_err k=%0d n=%0d got=%b exp=%b", k, n, rsp_err[k], e_er); end
            if (rsp_data[k] !== e_rd) begin fails++; $display("FAIL rsp_data k=%0d n=%0d got=%h exp=%h", k, n, rsp_data[k], e_rd); end
            if (busy[k] !== 1'b1) begin fails++; $display("FAIL busy k=%0d n=%0d got=%b exp=1", k, n, busy[k]); end
            if (req_ready[k] !== e_rv) begin fails++; $display("FAIL req_ready k=%0d n=%0d got=%b exp=%b", k, n, req_ready[k], e_rv); end
            if (n == 1) begin
                if (hold) begin
                    req_src[k] = nsrc; req_dst[k] = ndst; req_data[k] = ndata;
                end else begin
                    req_valid[k] = 1'b0;
                    req_src[k] = 3'($urandom); req_dst[k] = 3'($urandom); req_data[k] = 8'($urandom);
                end
            end
            if (n == rst_at) begin
                reset[k] = 1'b1;
                @(negedge clk);
                tests += 5;
                if (reg_we[k] !== 4'b0000) begin fails++; $display("FAIL rst_we k=%0d got=%b exp=0000", k, reg_we[k]); end
                if (reg_ws[k] !== 4'b0000) begin fails++; $display("FAIL rst_ws k=%0d got=%b exp=0000", k, reg_ws[k]); end
                if (busy[k] !== 1'b0) begin fails++; $display("FAIL rst_busy k=%0d got=%b exp=0", k, busy[k]); end
                if (bus_oe[k] !== 1'b0) begin fails++; $display("FAIL rst_oe k=%0d got=%b exp=0", k, bus_oe[k]); end
                if (rsp_data[k] !== 8'h00) begin fails++; $display("FAIL rst_rsp_data k=%0d got=%h exp=00", k, rsp_data[k]); end
                reset[k] = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    tests += 3;
                    if (rsp_valid[k] !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid k=%0d j=%0d got=%b exp=0", k, j, rsp_valid[k]); end
                    if (req_ready[k] !== 1'b1) begin fails++; $display("FAIL rst_ready k=%0d j=%0d got=%b exp=1", k, j, req_ready[k]); end
                    if (busy[k] !== 1'b0) begin fails++; $display("FAIL rst_idle_busy k=%0d j=%0d got=%b exp=0", k, j, busy[k]); end
                end
                return;
            end
        end
        exp_rsp[k] = rsp_new;
        if (ok && dst < 3'(N)) exp_regs[k][dst] = reg_new;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (env_regs[k][i] !== exp_regs[k][i]) begin
                fails++;
                $display("FAIL reg_contents k=%0d r%0d got=%h exp=%h", k, i, env_regs[k][i], exp_regs[k][i]);
            end
        end
    endtask

    task automatic xfer(input int k, input logic [2:0] src, input logic [2:0] dst, input logic [7:0] data);
        int w;
        do_xfer(k, src, dst, data, 1'b0, 3'd0, 3'd0, 8'h00, 0, w);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; req_valid[k] = 1'b0;
            req_src[k] = 3'd0; req_dst[k] = 3'd0; req_data[k] = 8'h00;
            exp_rsp[k] = 8'h00;
            for (int i = 0; i < N; i++) exp_regs[k][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests += 7;
            if (reg_we[k] !== 4'b0000) begin fails++; $display("FAIL reset_we k=%0d got=%b exp=0000", k, reg_we[k]); end
            if (reg_ws[k] !== 4'b0000) begin fails++; $display("FAIL reset_ws k=%0d got=%b exp=0000", k, reg_ws[k]); end
            if (bus_oe[k] !== 1'b0 || bus_out[k] !== 8'h00) begin fails++; $display("FAIL reset_bus k=%0d got=%b/%h exp=0/00", k, bus_oe[k], bus_out[k]); end
            if (rsp_valid[k] !== 1'b0 || rsp_err[k] !== 1'b0) begin fails++; $display("FAIL reset_rsp k=%0d got=%b/%b exp=0/0", k, rsp_valid[k], rsp_err[k]); end
            if (rsp_data[k] !== 8'h00) begin fails++; $display("FAIL reset_rsp_data k=%0d got=%h exp=00", k, rsp_data[k]); end
            if (busy[k] !== 1'b0) begin fails++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, busy[k]); end
            if (req_ready[k] !== 1'b1) begin fails++; $display("FAIL reset_ready k=%0d got=%b exp=1", k, req_ready[k]); end
        end
    endtask

    task automatic test_reg_to_reg();
        xfer(0, 3'd4, 3'd1, 8'hA5);
        xfer(0, 3'd1, 3'd2, 8'h00);
        tests++;
        if (env_regs[0][2] !== 8'hA5) begin fails++; $display("FAIL r2_after_copy got=%h exp=a5", env_regs[0][2]); end
    endtask

    task automatic test_host_write();
        xfer(0, 3'd4, 3'd0, 8'h3C);
        tests++;
        if (env_regs[0][0] !== 8'h3C) begin fails++; $display("FAIL r0_after_host_write got=%h exp=3c", env_regs[0][0]); end
    endtask

    task automatic test_host_read();
        xfer(0, 3'd4, 3'd3, 8'h7E);
        xfer(0, 3'd3, 3'd4, 8'h00);
        xfer(0, 3'd4, 3'd1, 8'h99);
        tests++;
        if (rsp_data[0] !== 8'h7E) begin fails++; $display("FAIL rsp_data_held got=%h exp=7e", rsp_data[0]); end
    endtask

    task automatic test_errors();
        xfer(0, 3'd2, 3'd2, 8'h11);
        xfer(0, 3'd5, 3'd0, 8'h22);
        xfer(0, 3'd4, 3'd4, 8'h33);
        xfer(0, 3'd1, 3'd7, 8'h44);
    endtask

    task automatic test_back_to_back();
        int w;
        do_xfer(0, 3'd4, 3'd2, 8'h5A, 1'b1, 3'd2, 3'd3, 8'h00, 0, w);
        do_xfer(0, 3'd2, 3'd3, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00, 0, w);
        tests++;
        if (w != 0) begin fails++; $display("FAIL b2b_accept_in_done waited=%0d exp=0", w); end
    endtask

    task automatic test_settle3();
        xfer(1, 3'd4, 3'd1, 8'hC3);
        xfer(1, 3'd1, 3'd2, 8'h00);
        xfer(1, 3'd2, 3'd4, 8'h00);
        xfer(1, 3'd0, 3'd0, 8'h00);
    endtask

    // Random chains, optionally back-to-back, covering valid and rejected selects
    task automatic test_random();
        logic [2:0] cs, cd, ns, nd;
        logic [7:0] cdat, ndat;
        bit hold;
        int w;
        for (int k = 0; k < 2; k++) begin
            cs = 3'($urandom_range(0, 4)); cd = 3'($urandom_range(0, 4)); cdat = 8'($urandom);
            for (int t = 0; t < ((k == 0) ? 30 : 15); t++) begin
                ns = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
                nd = 3'($urandom_range(0, 4));
                ndat = 8'($urandom);
                hold = 1'($urandom);
                do_xfer(k, cs, cd, cdat, hold, ns, nd, ndat, 0, w);
                if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
                cs = ns; cd = nd; cdat = ndat;
            end
        end
    endtask

    task automatic test_reset_in_set();
        int w;
        do_xfer(0, 3'd0, 3'd3, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00, 2, w);
    endtask

    initial begin
        test_reset();
        test_reg_to_reg();
        test_host_write();
        test_host_read();
        test_errors();
        test_back_to_back();
        test_settle3();
        test_random();
        test_reset_in_set();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

endmodule
